// File: rtl/neopixel_frame_ctrl.sv
// APB register front end and frame sequencer for the NeoPixel transmitter.
// Zero-wait-state APB, pixel writes pass straight through, TX_START one cycle after START/TX_DONE.
module neopixel_frame_ctrl #(
    parameter int          PIXELS_MAX  = 5,
    parameter int          PIXELS_BITS = 3,
    parameter logic [15:0] TIMEOUT     = 16'd60000
) (
    input  logic                   CLK_10MHZ,
    input  logic                   APB_PRESERN,
    input  logic [7:0]             APB_PADDR,
    input  logic                   APB_PSELx,
    input  logic                   APB_PENABLE,
    input  logic                   APB_PWRITE,
    input  logic [7:0]             APB_PWDATA,
    output logic                   APB_PREADY,
    output logic                   APB_PSLVERR,
    output logic [7:0]             APB_PRDATA,
    output logic                   PIX_WE,
    output logic [PIXELS_BITS-1:0] PIX_WADDR,
    output logic [7:0]             PIX_WDATA,
    output logic                   TX_START,
    output logic [PIXELS_BITS-1:0] TX_LENGTH,
    input  logic                   TX_DONE,
    output logic                   IRQ
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [7:0]             PIX_LIM = 8'(PIXELS_MAX);
    localparam logic [PIXELS_BITS-1:0] LEN_RST = PIXELS_BITS'(PIXELS_MAX);

    logic [1:0]             state_q, state_d;
    logic                   cont_q, cont_d;
    logic                   irq_en_q, irq_en_d;
    logic [PIXELS_BITS-1:0] length_q, length_d;
    logic                   done_q, done_d;
    logic                   toerr_q, toerr_d;
    logic                   pending_q, pending_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [PIXELS_BITS-1:0] tx_len_q, tx_len_d;
    logic                   irq_q, irq_d;

    logic access, wr, rd, busy;
    logic is_pix, is_ctrl, is_len, is_stat, len_ok, start_wr;

    // Outputs are gated by reset so they drop to 0 the moment reset asserts.
    assign access   = APB_PSELx & APB_PENABLE & APB_PRESERN;
    assign wr       = access & APB_PWRITE;
    assign rd       = access & ~APB_PWRITE;
    assign busy     = (state_q != ST_IDLE);
    assign is_pix   = (APB_PADDR < PIX_LIM);
    assign is_ctrl  = (APB_PADDR == 8'h80);
    assign is_len   = (APB_PADDR == 8'h81);
    assign is_stat  = (APB_PADDR == 8'h82);
    assign len_ok   = (APB_PWDATA != 8'd0) && (APB_PWDATA <= PIX_LIM) && !busy;
    assign start_wr = wr & is_ctrl & APB_PWDATA[0];

    assign APB_PREADY  = access;
    assign APB_PSLVERR = access & (~(is_pix | is_ctrl | is_len | is_stat) | (APB_PWRITE & is_len & ~len_ok));

    always_comb begin
        APB_PRDATA = 8'd0;
        if (rd) begin
            if (is_ctrl)      APB_PRDATA = {5'd0, irq_en_q, cont_q, 1'b0};
            else if (is_len)  APB_PRDATA = 8'(length_q);
            else if (is_stat) APB_PRDATA = {4'd0, pending_q, toerr_q, done_q, busy};
        end
    end

    assign PIX_WE    = wr & is_pix;
    assign PIX_WADDR = PIX_WE ? APB_PADDR[PIXELS_BITS-1:0] : '0;
    assign PIX_WDATA = PIX_WE ? APB_PWDATA : 8'd0;
    assign TX_START  = (state_q == ST_ARM);
    assign TX_LENGTH = tx_len_q;
    assign IRQ       = irq_q;

    always_comb begin
        state_d   = state_q;
        cont_d    = cont_q;
        irq_en_d  = irq_en_q;
        length_d  = length_q;
        done_d    = done_q;
        toerr_d   = toerr_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        tx_len_d  = tx_len_q;

        if (wr && is_ctrl) begin
            cont_d   = APB_PWDATA[1];
            irq_en_d = APB_PWDATA[2];
        end
        if (wr && is_len && len_ok) length_d = APB_PWDATA[PIXELS_BITS-1:0];
        if (wr && is_stat) begin
            if (APB_PWDATA[1]) done_d  = 1'b0;
            if (APB_PWDATA[2]) toerr_d = 1'b0;
        end
        if (start_wr && busy) pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_wr || pending_q) begin
                    state_d  = ST_ARM;
                    tx_len_d = length_q;
                end
            end
            ST_ARM: begin
                // A START landing in the ARM cycle itself must still queue a frame.
                pending_d = start_wr;
                cnt_d     = 16'd0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 16'd1;
                if (TX_DONE) begin
                    done_d = 1'b1;
                    if (pending_q || start_wr || cont_q) begin
                        state_d  = ST_ARM;
                        tx_len_d = length_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_d == TIMEOUT) begin
                    toerr_d   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        irq_d = irq_en_d & (done_d | toerr_d);
    end

    always_ff @(posedge CLK_10MHZ or negedge APB_PRESERN) begin
        if (!APB_PRESERN) begin
            state_q   <= ST_IDLE;
            cont_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            length_q  <= LEN_RST;
            done_q    <= 1'b0;
            toerr_q   <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= 16'd0;
            tx_len_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cont_q    <= cont_d;
            irq_en_q  <= irq_en_d;
            length_q  <= length_d;
            done_q    <= done_d;
            toerr_q   <= toerr_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            tx_len_q  <= tx_len_d;
            irq_q     <= irq_d;
        end
    end

endmodule
